// File: rtl/sort4_pkg.sv
`default_nettype none
// ============================================================================
// Module : sort4_pkg
// Brief  : Shared types and constants for the sort4 serializer slice.
// Rev    : 1.0
// ============================================================================
package sort4_pkg;

    localparam int NLANES = 4;
    localparam int IDX_W  = 2;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_SEND  = 1'b1
    } state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    // Lane feeding beat 'cnt': ascending walks 0..3, descending walks 3..0.
    function automatic logic [IDX_W-1:0] lane_sel(
        input logic [IDX_W-1:0] cnt,
        input logic             desc
    );
        return (desc == DIR_DESC) ? (IDX_W'(NLANES - 1) - cnt) : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort4_order_check.sv
`default_nettype none
// ============================================================================
// Module : sort4_order_check
// Brief  : Combinational non-decreasing (unsigned) order check of a 4-lane word.
// Rev    : 1.0
// ============================================================================
module sort4_order_check
    import sort4_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [NLANES*DW-1:0] in,
    output logic                 ok
);

    logic [NLANES-2:0] w_le;

    for (genvar k = 0; k < NLANES - 1; k++) begin : g_cmp
        assign w_le[k] = (in[DW*k +: DW] <= in[DW*(k+1) +: DW]);
    end

    assign ok = &w_le;

endmodule
`default_nettype wire

// File: rtl/sort4_serializer.sv
`default_nettype none
// ============================================================================
// Module : sort4_serializer
// Brief  : Accepts a 4-lane sorted word, streams it one element per beat with
//          idx/last tags, flags order violations and counts finished words.
// Rev    : 1.0
// ============================================================================
module sort4_serializer
    import sort4_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NLANES*DW-1:0] in_data,
    input  logic                 in_desc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic                 sort_err,
    input  logic                 err_clr,
    output logic [CNTW-1:0]      word_cnt
);

    state_t                r_state;
    logic [IDX_W-1:0]      r_cnt;
    logic [NLANES*DW-1:0]  r_hold;
    logic                  r_desc;
    logic                  r_sort_err;
    logic [CNTW-1:0]       r_word_cnt;

    logic                  w_accept;
    logic                  w_beat;
    logic                  w_word_done;
    logic                  w_order_ok;
    logic [IDX_W-1:0]      w_lane;

    sort4_order_check #(
        .DW (DW)
    ) u_order_check (
        .in (in_data),
        .ok (w_order_ok)
    );

    assign w_beat      = out_valid && out_ready;
    assign w_word_done = w_beat && (r_cnt == IDX_W'(NLANES - 1));
    // Reloading on the final beat keeps back-to-back words bubble-free.
    assign in_ready    = (r_state == S_EMPTY) || w_word_done;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_desc     <= DIR_ASC;
            r_sort_err <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_hold  <= in_data;
                r_desc  <= in_desc;
                r_cnt   <= '0;
                r_state <= S_SEND;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_word_done) begin
                    r_state <= S_EMPTY;
                end
            end

            if (w_word_done) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            // A fresh violation takes priority over a clear in the same cycle.
            if (w_accept && !w_order_ok) begin
                r_sort_err <= 1'b1;
            end else if (err_clr) begin
                r_sort_err <= 1'b0;
            end
        end
    end

    assign w_lane    = lane_sel(r_cnt, r_desc);
    assign out_valid = (r_state == S_SEND);
    assign out_data  = r_hold[w_lane*DW +: DW];
    assign out_idx   = r_cnt;
    assign out_last  = (r_state == S_SEND) && (r_cnt == IDX_W'(NLANES - 1));
    assign sort_err  = r_sort_err;
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sort4_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_sort4_serializer
// Brief  : Self-checking bench: directed table, corner sequences, random run
//          against a beat-queue reference model.
// Rev    : 1.0
// ============================================================================
module tb_sort4_serializer;

    localparam int DW   = 8;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] in_data;
    logic            in_desc;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_idx;
    logic            out_last;
    logic            sort_err;
    logic            err_clr;
    logic [CNTW-1:0] word_cnt;

    int n_chk = 0;
    int n_err = 0;

    sort4_serializer #(
        .DW   (DW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .sort_err  (sort_err),
        .err_clr   (err_clr),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            iv;
        logic [31:0]     d;
        logic            desc;
        logic            ordy;
        logic            clr;
        logic            e_ov;
        logic [7:0]      e_d;
        logic [1:0]      e_idx;
        logic            e_last;
        logic            e_ir;
        logic            e_err;
        logic [CNTW-1:0] e_wc;
    } vec_t;

    vec_t tbl [10];

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    beat_t mq[$];
    int    m_wc;
    logic  m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic desc,
                         input logic ordy, input logic clr);
        in_valid  = iv;
        in_data   = d;
        in_desc   = desc;
        out_ready = ordy;
        err_clr   = clr;
    endtask

    function automatic logic model_ir();
        return (mq.size() == 0) || (out_ready && mq.size() == 1);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_wc  = 0;
        m_err = 1'b0;
    endtask

    task automatic model_check();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(model_ir()));
        chk("sort_err",  32'(sort_err),  32'(m_err));
        chk("word_cnt",  32'(word_cnt),  32'(m_wc));
        if (mq.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0].d));
            chk("out_idx",  32'(out_idx),  32'(mq[0].idx));
            chk("out_last", 32'(out_last), 32'(mq[0].last));
        end
    endtask

    // Reference: a word becomes four queued beats; the head of the queue is the
    // beat on the bus.
    task automatic model_step();
        logic  ir;
        logic  acc;
        logic  sorted;
        beat_t b;
        int    lane;
        ir     = model_ir();
        acc    = in_valid && ir;
        sorted = 1'b1;
        if (mq.size() != 0 && out_ready) begin
            b = mq.pop_front();
            if (b.last) m_wc = (m_wc + 1) % (1 << CNTW);
        end
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                lane  = in_desc ? 3 - k : k;
                b.d   = in_data[lane*8 +: 8];
                b.idx = 2'(k);
                b.last = (k == 3);
                mq.push_back(b);
            end
            for (int k = 0; k < 3; k++)
                if (in_data[k*8 +: 8] > in_data[(k+1)*8 +: 8]) sorted = 1'b0;
        end
        if (acc && !sorted) m_err = 1'b1;
        else if (err_clr)   m_err = 1'b0;
    endtask

    task automatic mc(input logic iv, input logic [31:0] d, input logic desc,
                      input logic ordy, input logic clr);
        drive(iv, d, desc, ordy, clr);
        #1;
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [7:0] a [4];
        logic [7:0] t;
        int narrow;
        narrow = ($urandom_range(0, 3) == 0) ? 1 : 0;
        for (int k = 0; k < 4; k++)
            a[k] = (narrow != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3 - i; j++)
                    if (a[j] > a[j+1]) begin
                        t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                    end
        end
        return {a[3], a[2], a[1], a[0]};
    endfunction

    localparam logic [31:0] WA  = 32'h4030_2010;
    localparam logic [31:0] WB  = 32'h4433_2211;
    localparam logic [31:0] BAD = 32'h1020_3040;

    initial begin
        tbl[0] = '{1'b1, WA,            1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[4] = '{1'b1, WA,            1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 2'd3, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[6] = '{1'b1, 32'h00FF_00FF, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 2'd1, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 2'd2, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 2'd3, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[9] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 3'd2};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_sort_err",  32'(sort_err),  32'd0);
        chk("rst_word_cnt",  32'(word_cnt),  32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: ascending word, then descending word back-to-back.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].desc, tbl[i].ordy, tbl[i].clr);
            #1;
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
            chk("tbl_in_ready",  32'(in_ready),  32'(tbl[i].e_ir));
            chk("tbl_sort_err",  32'(sort_err),  32'(tbl[i].e_err));
            chk("tbl_word_cnt",  32'(word_cnt),  32'(tbl[i].e_wc));
            if (tbl[i].e_ov) begin
                chk("tbl_out_data", 32'(out_data), 32'(tbl[i].e_d));
                chk("tbl_out_idx",  32'(out_idx),  32'(tbl[i].e_idx));
                chk("tbl_out_last", 32'(out_last), 32'(tbl[i].e_last));
            end
            model_step();
            @(posedge clk);
            #1;
        end

        // Stall at idx 1 for three cycles while another word is offered.
        mc(1'b1, WB, 1'b0, 1'b1, 1'b0);
        mc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) mc(1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0);
        repeat (4) mc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Unsorted word: flagged, streamed unmodified, cleared, set-wins on clear.
        mc(1'b1, BAD, 1'b0, 1'b1, 1'b0);
        repeat (4) mc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        mc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        mc(1'b1, BAD, 1'b0, 1'b1, 1'b1);
        repeat (2) mc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-word, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_sort_err",  32'(sort_err),  32'd0);
        chk("arst_word_cnt",  32'(word_cnt),  32'd0);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) mc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic; the 3-bit word counter wraps many times.
        for (int i = 0; i < 600; i++) begin
            mc(($urandom_range(0, 2) != 0),
               rand_word(),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
